rf_multiport_sb: RTL and testbench
==================================

RF_MULTIPORT_SB -- requirements
Module: rf_multiport_sb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, address width; NUM_WORDS = 2**ADDR_WIDTH registers.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports raddr_a_i, raddr_b_i, raddr_c_i  input  ADDR_WIDTH  read addresses, ports A/B/C.
REQ-006 SHALL have ports rdata_a_o, rdata_b_o, rdata_c_o  output  DATA_WIDTH  read data, ports A/B/C.
REQ-007 SHALL have ports busy_a_o, busy_b_o, busy_c_o  output  1  scoreboard busy bit of the register addressed by the matching read port.
REQ-008 SHALL have ports waddr_a_i  input  ADDR_WIDTH, wdata_a_i  input  DATA_WIDTH, we_a_i  input  1  write port A (ALU writeback).
REQ-009 SHALL have ports waddr_b_i  input  ADDR_WIDTH, wdata_b_i  input  DATA_WIDTH, we_b_i  input  1  write port B (LSU writeback).
REQ-010 SHALL have ports lock_addr_i  input  ADDR_WIDTH, lock_i  input  1  marks destination register busy at issue.

Function
REQ-011 Register 0 SHALL always read 0, ignore writes, and never be busy.
REQ-012 Reads SHALL be combinational: rdata_x_o = mem[raddr_x_i], zero latency.
REQ-013 A write with we_x_i=1 to address n != 0 SHALL update mem[n] at the next rising edge.
REQ-014 Simultaneous writes A and B to the same address SHALL store wdata_b_i (port B wins); different addresses SHALL both be stored.
REQ-015 Scoreboard SHALL hold one busy bit per register; lock_i=1 SHALL set busy[lock_addr_i] at the next edge.
REQ-016 A write on either port to address n SHALL clear busy[n] at the same edge the data is stored.
REQ-017 Lock and write to the same address in the same cycle SHALL leave busy set (new issue beats old writeback); data SHALL still be stored.
REQ-018 busy_x_o SHALL be combinational from the registered scoreboard: busy[raddr_x_i], no same-cycle bypass of lock or clear.
REQ-019 Lock of a register already busy SHALL keep it busy; write to a non-busy register SHALL store data and leave busy clear.
REQ-020 Addresses SHALL be full NUM_WORDS range; no out-of-range case exists.

Reset
REQ-021 rst_n=0 SHALL asynchronously clear all mem words and all busy bits; all rdata_x_o and busy_x_o SHALL read 0 during reset.
REQ-022 Writes or locks presented while rst_n=0 SHALL be discarded; first update occurs at the first rising edge after rst_n deasserts.
REQ-023 Reset asserted mid-operation SHALL clear in-flight busy bits regardless of pending writebacks.

Configuration
REQ-024 Macro RF_WRITE_BYPASS_EN, when defined, SHALL forward same-cycle write data to read ports: if we_x_i and waddr_x_i == raddr_y_i != 0, rdata_y_o = wdata (port B priority), and busy_y_o = 0 unless lock_i targets the same address that cycle.
REQ-025 Without RF_WRITE_BYPASS_EN, reads SHALL return the pre-edge stored value and busy_y_o SHALL reflect registered state only (REQ-018).

Verification
REQ-026 Reset then read all addresses on A/B/C -> all rdata 0, all busy 0.
REQ-027 we_a=1 waddr_a=5 wdata_a=0xDEADBEEF, next cycle raddr_c=5 -> rdata_c_o=0xDEADBEEF; write 0x1234 to address 0 -> rdata_a_o for address 0 stays 0.
REQ-028 Same cycle we_a=1 wdata_a=0x11, we_b=1 wdata_b=0x22, both waddr=7 -> mem[7]=0x22 next cycle.
REQ-029 lock_i=1 lock_addr=9; next cycle busy_b_o=1 at raddr_b=9; we_b=1 waddr_b=9 with lock_i=1 lock_addr=9 -> busy stays 1; then we_a=1 waddr_a=9 alone -> busy 0.
REQ-030 With RF_WRITE_BYPASS_EN: we_a=1 waddr_a=3 wdata_a=0xA5A5A5A5, raddr_a=3 same cycle -> rdata_a_o=0xA5A5A5A5 that cycle; without macro -> old value that cycle.
REQ-031 Lock registers 1..4, assert rst_n=0 between clock edges -> busy and data 0 immediately, no further updates until deassertion.

Source files
------------

// File: rtl/rf_multiport_sb.sv
// Three-read / two-write register file with a per-register busy scoreboard.
// Optional macro RF_WRITE_BYPASS_EN forwards same-cycle write data to the read ports.
module rf_multiport_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  input  logic [ADDR_WIDTH-1:0] raddr_c_i,
  output logic [DATA_WIDTH-1:0] rdata_a_o,
  output logic [DATA_WIDTH-1:0] rdata_b_o,
  output logic [DATA_WIDTH-1:0] rdata_c_o,
  output logic                  busy_a_o,
  output logic                  busy_b_o,
  output logic                  busy_c_o,
  input  logic [ADDR_WIDTH-1:0] waddr_a_i,
  input  logic [DATA_WIDTH-1:0] wdata_a_i,
  input  logic                  we_a_i,
  input  logic [ADDR_WIDTH-1:0] waddr_b_i,
  input  logic [DATA_WIDTH-1:0] wdata_b_i,
  input  logic                  we_b_i,
  input  logic [ADDR_WIDTH-1:0] lock_addr_i,
  input  logic                  lock_i
);

  localparam int NUM_WORDS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [NUM_WORDS];
  logic [NUM_WORDS-1:0]  r_busy;
  logic [NUM_WORDS-1:0]  w_busy_next;

  logic [ADDR_WIDTH-1:0] w_raddr   [3];
  logic [DATA_WIDTH-1:0] w_rdata   [3];
  logic                  w_busy_rd [3];

  // A new issue (lock) is applied after the writeback clears, so it wins.
  always_comb begin
    w_busy_next = r_busy;
    if (we_a_i) w_busy_next[waddr_a_i] = 1'b0;
    if (we_b_i) w_busy_next[waddr_b_i] = 1'b0;
    if (lock_i) w_busy_next[lock_addr_i] = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  // Word 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WORDS; i++) r_mem[i] <= '0;
      r_busy <= '0;
    end else begin
      for (int i = 1; i < NUM_WORDS; i++) begin
        if (we_b_i && (waddr_b_i == ADDR_WIDTH'(i)))
          r_mem[i] <= wdata_b_i;
        else if (we_a_i && (waddr_a_i == ADDR_WIDTH'(i)))
          r_mem[i] <= wdata_a_i;
      end
      r_busy <= w_busy_next;
    end
  end

  assign w_raddr[0] = raddr_a_i;
  assign w_raddr[1] = raddr_b_i;
  assign w_raddr[2] = raddr_c_i;

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      w_rdata[p]   = r_mem[w_raddr[p]];
      w_busy_rd[p] = r_busy[w_raddr[p]];
`ifdef RF_WRITE_BYPASS_EN
      // Forwarding is suppressed in reset so outputs read zero while rst_n is low.
      if (rst_n && (w_raddr[p] != '0)) begin
        if (we_b_i && (waddr_b_i == w_raddr[p])) begin
          w_rdata[p]   = wdata_b_i;
          w_busy_rd[p] = w_busy_rd[p] & lock_i & (lock_addr_i == w_raddr[p]);
        end else if (we_a_i && (waddr_a_i == w_raddr[p])) begin
          w_rdata[p]   = wdata_a_i;
          w_busy_rd[p] = w_busy_rd[p] & lock_i & (lock_addr_i == w_raddr[p]);
        end
      end
`endif
    end
  end

  assign rdata_a_o = w_rdata[0];
  assign rdata_b_o = w_rdata[1];
  assign rdata_c_o = w_rdata[2];
  assign busy_a_o  = w_busy_rd[0];
  assign busy_b_o  = w_busy_rd[1];
  assign busy_c_o  = w_busy_rd[2];

endmodule

// File: tb/tb_rf_multiport_sb.sv
// Directed plus randomized bench for rf_multiport_sb against an array-based model
// of the register file rules (storage, port-B priority, scoreboard set/clear).
module tb_rf_multiport_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NW = 32;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] raddr_a, raddr_b, raddr_c;
  logic [DW-1:0] rdata_a, rdata_b, rdata_c;
  logic          busy_a, busy_b, busy_c;
  logic [AW-1:0] waddr_a, waddr_b, lock_addr;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          we_a, we_b, lock;

  int tests_run = 0;
  int tests_failed = 0;

  logic [DW-1:0] m_mem  [NW];
  logic          m_busy [NW];
  logic [DW-1:0] exp_q[$];

  rf_multiport_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b), .raddr_c_i(raddr_c),
    .rdata_a_o(rdata_a), .rdata_b_o(rdata_b), .rdata_c_o(rdata_c),
    .busy_a_o(busy_a), .busy_b_o(busy_b), .busy_c_o(busy_c),
    .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
    .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
    .lock_addr_i(lock_addr), .lock_i(lock)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Expected read data: stored value, or same-cycle write data when forwarding is built in.
  function automatic logic [DW-1:0] exp_rdata(input logic [AW-1:0] a);
    if (!rst_n) return '0;
`ifdef RF_WRITE_BYPASS_EN
    if (a != 0 && we_b && waddr_b == a) return wdata_b;
    if (a != 0 && we_a && waddr_a == a) return wdata_a;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (!rst_n) return 1'b0;
`ifdef RF_WRITE_BYPASS_EN
    if (a != 0 && ((we_b && waddr_b == a) || (we_a && waddr_a == a)))
      return m_busy[a] && lock && (lock_addr == a);
`endif
    return m_busy[a];
  endfunction

  // scoreboard: queue expected values for all six outputs and pop them against the DUT
  task automatic check_ports(input string tag);
    #1;
    exp_q.push_back(exp_rdata(raddr_a));
    exp_q.push_back(exp_rdata(raddr_b));
    exp_q.push_back(exp_rdata(raddr_c));
    exp_q.push_back(DW'(exp_busy(raddr_a)));
    exp_q.push_back(DW'(exp_busy(raddr_b)));
    exp_q.push_back(DW'(exp_busy(raddr_c)));
    check({tag, ".rdata_a"}, rdata_a, exp_q.pop_front());
    check({tag, ".rdata_b"}, rdata_b, exp_q.pop_front());
    check({tag, ".rdata_c"}, rdata_c, exp_q.pop_front());
    check({tag, ".busy_a"}, DW'(busy_a), exp_q.pop_front());
    check({tag, ".busy_b"}, DW'(busy_b), exp_q.pop_front());
    check({tag, ".busy_c"}, DW'(busy_c), exp_q.pop_front());
  endtask

  task automatic model_reset();
    for (int i = 0; i < NW; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Apply one rising edge to the model: data stored (B over A), writes free, lock claims.
  task automatic tick(input string tag);
    logic          s_we_a, s_we_b, s_lock, s_rst;
    logic [AW-1:0] s_wa, s_wb, s_la;
    logic [DW-1:0] s_da, s_db;
    check_ports(tag);
    s_we_a = we_a; s_wa = waddr_a; s_da = wdata_a;
    s_we_b = we_b; s_wb = waddr_b; s_db = wdata_b;
    s_lock = lock; s_la = lock_addr; s_rst = rst_n;
    @(posedge clk);
    if (s_rst) begin
      if (s_we_a && s_wa != 0) begin m_mem[s_wa] = s_da; m_busy[s_wa] = 1'b0; end
      if (s_we_b && s_wb != 0) begin m_mem[s_wb] = s_db; m_busy[s_wb] = 1'b0; end
      if (s_lock && s_la != 0) m_busy[s_la] = 1'b1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    we_a = 1'b0; we_b = 1'b0; lock = 1'b0;
    waddr_a = '0; waddr_b = '0; lock_addr = '0;
    wdata_a = '0; wdata_b = '0;
  endtask

  task automatic set_reads(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] c);
    raddr_a = a; raddr_b = b; raddr_c = c;
  endtask

  initial begin
    // Reset with writes and locks being presented; they must be discarded.
    rst_n = 1'b0;
    model_reset();
    set_reads('0, '0, '0);
    we_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'hCAFE_F00D;
    we_b = 1'b1; waddr_b = 5'd6; wdata_b = 32'hBEEF_0001;
    lock = 1'b1; lock_addr = 5'd7;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NW; i++) begin
      set_reads(AW'(i), AW'(i), AW'(i));
      check_ports("reset_all");
    end
    idle_inputs();
    rst_n = 1'b1;
    for (int i = 0; i < NW; i++) begin
      set_reads(AW'(i), AW'(i), AW'(i));
      check_ports("post_reset");
    end

    // Basic write then read, and register 0 ignores writes.
    we_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'hDEAD_BEEF;
    tick("wr5");
    idle_inputs();
    set_reads('0, '0, 5'd5);
    #1 check("rd5_c", rdata_c, 32'hDEAD_BEEF);
    we_a = 1'b1; waddr_a = '0; wdata_a = 32'h0000_1234;
    tick("wr0");
    idle_inputs();
    set_reads('0, '0, '0);
    #1 check("rd0_a", rdata_a, '0);
    check("rd0_busy", DW'(busy_a), '0);

    // Same-address collision: port B wins.
    we_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'h11;
    we_b = 1'b1; waddr_b = 5'd7; wdata_b = 32'h22;
    tick("coll7");
    idle_inputs();
    set_reads(5'd7, 5'd7, 5'd5);
    #1 check("coll7_b_wins", rdata_a, 32'h22);
    check_ports("coll7_after");

    // Scoreboard: lock, lock+write same cycle keeps busy, lone write clears.
    lock = 1'b1; lock_addr = 5'd9;
    set_reads('0, 5'd9, '0);
    #1 check("lock9_no_bypass", DW'(busy_b), '0);
    tick("lock9");
    idle_inputs();
    #1 check("busy9_set", DW'(busy_b), 32'd1);
    we_b = 1'b1; waddr_b = 5'd9; wdata_b = 32'h9999;
    lock = 1'b1; lock_addr = 5'd9;
    tick("lockwr9");
    idle_inputs();
    #1 check("busy9_kept", DW'(busy_b), 32'd1);
    check("data9_stored", rdata_b, 32'h9999);
    we_a = 1'b1; waddr_a = 5'd9; wdata_a = 32'h9A9A;
    tick("wr9");
    idle_inputs();
    #1 check("busy9_clear", DW'(busy_b), '0);
    check("data9_new", rdata_b, 32'h9A9A);

    // Same-cycle read of a location being written.
    we_a = 1'b1; waddr_a = 5'd3; wdata_a = 32'h1111_1111;
    tick("wr3_old");
    we_a = 1'b1; waddr_a = 5'd3; wdata_a = 32'hA5A5_A5A5;
    set_reads(5'd3, '0, '0);
`ifdef RF_WRITE_BYPASS_EN
    #1 check("bypass3", rdata_a, 32'hA5A5_A5A5);
`else
    #1 check("nobypass3", rdata_a, 32'h1111_1111);
`endif
    tick("wr3_new");
    idle_inputs();
    #1 check("rd3_after", rdata_a, 32'hA5A5_A5A5);

    // Randomized traffic; addresses sometimes narrowed to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      logic narrow;
      narrow    = ($urandom_range(0, 1) == 1);
      we_a      = ($urandom_range(0, 2) != 0);
      we_b      = ($urandom_range(0, 2) != 0);
      lock      = ($urandom_range(0, 1) == 1);
      waddr_a   = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
      waddr_b   = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
      lock_addr = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
      wdata_a   = $urandom;
      wdata_b   = $urandom;
      set_reads(narrow ? AW'($urandom_range(0, 3)) : AW'($urandom),
                narrow ? AW'($urandom_range(0, 3)) : AW'($urandom),
                AW'($urandom));
      tick("rand");
    end
    idle_inputs();

    // Mid-operation reset with in-flight locks and pending writebacks.
    for (int i = 1; i <= 4; i++) begin
      lock = 1'b1; lock_addr = AW'(i);
      we_a = 1'b1; waddr_a = AW'(i); wdata_a = 32'h100 + DW'(i);
      tick("lock1_4");
    end
    idle_inputs();
    set_reads(5'd1, 5'd2, 5'd4);
    #1 check("busy1_set", DW'(busy_a), 32'd1);
    check("busy4_set", DW'(busy_c), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1 check("rst_busy1", DW'(busy_a), '0);
    check("rst_data2", rdata_b, '0);
    check_ports("rst_mid");
    we_b = 1'b1; waddr_b = 5'd2; wdata_b = 32'h7777;
    lock = 1'b1; lock_addr = 5'd4;
    tick("rst_hold1");
    tick("rst_hold2");
    idle_inputs();
    rst_n = 1'b1;
    check_ports("rst_release");
    we_b = 1'b1; waddr_b = 5'd2; wdata_b = 32'h7777;
    lock = 1'b1; lock_addr = 5'd4;
    tick("first_update");
    idle_inputs();
    #1 check("first_upd_data", rdata_b, 32'h7777);
    check("first_upd_busy", DW'(busy_c), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
